// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg -- shared definitions for the reset sequencer.
//
// Holds the FSM state encoding (also exported on state_o for debug), the
// default parameter values used by rst_seq_ctrl, and small saturating
// increment helpers for the counters, which must never wrap.

`timescale 1ns/1ps

package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int unsigned DEF_N_STAGES    = 4;
  localparam logic [15:0] DEF_STAGE_DLY   = 16'h00ff;
  localparam int unsigned DEF_LOCK_FILT   = 8;
  localparam logic [15:0] DEF_ACK_TIMEOUT = 16'hffff;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hffff) ? value : value + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hff) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync -- reset synchronizer (asynchronous assert, synchronous deassert).
//
// Ports:
//   clk      : destination clock
//   rst      : raw asynchronous active-high reset
//   sync_rst : active-high reset, asserts with rst, deasserts two clk edges
//              after rst falls

`timescale 1ns/1ps

module rst_sync (
  input  logic clk,
  input  logic rst,
  output logic sync_rst
);

  logic meta;

  // Both flops preset together so the output rises as soon as rst does;
  // a zero then walks through the pair before reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_rst <= 1'b1;
    end else begin
      meta     <= 1'b0;
      sync_rst <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl -- power-up reset sequencer.
//
// Waits for a filtered PLL lock, then releases N_STAGES reset outputs one at
// a time in ascending index order, STAGE_DLY cycles per stage.  Losing lock
// after the sequence has started drops every stage back into reset and
// restarts from WAIT_LOCK, counting the event in relock_cnt_o.
//
// Build option: define RST_SEQ_ACK_EN to make each stage wait for its
// stage_ack_i bit before the next one starts; a missing acknowledge for
// ACK_TIMEOUT cycles parks the sequencer in FAULT until rst_i.  Without the
// macro stage_ack_i is ignored and fault_o is tied low.
//
// Ports:
//   clk_i        : single clock
//   rst_i        : asynchronous active-high reset (power-on reset pulse)
//   pll_lock_i   : PLL lock, asynchronous, double-flopped here
//   stage_ack_i  : per-stage init-done (ACK build only)
//   stage_rst_o  : per-stage active-high reset
//   all_ready_o  : high only in RUN
//   fault_o      : sticky acknowledge-timeout flag
//   relock_cnt_o : lock losses since reset, saturating at 8'hff
//   state_o      : current FSM state for debug

`timescale 1ns/1ps

module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_STAGES    = DEF_N_STAGES,
  parameter logic [15:0] STAGE_DLY   = DEF_STAGE_DLY,
  parameter int unsigned LOCK_FILT   = DEF_LOCK_FILT,
  parameter logic [15:0] ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pll_lock_i,
  input  logic [N_STAGES-1:0] stage_ack_i,
  output logic [N_STAGES-1:0] stage_rst_o,
  output logic                all_ready_o,
  output logic                fault_o,
  output logic [7:0]          relock_cnt_o,
  output logic [2:0]          state_o
);

  localparam logic [15:0]         STAGE_DLY_M1 = STAGE_DLY - 16'd1;
  localparam logic [15:0]         LOCK_FILT_M1 = 16'(LOCK_FILT - 1);
  localparam logic [N_STAGES-1:0] ONE_HOT0     = N_STAGES'(1);
`ifdef RST_SEQ_ACK_EN
  localparam logic [3:0]          LAST_IDX     = 4'(N_STAGES - 1);
  localparam logic [15:0]         ACK_TMO_M1   = ACK_TIMEOUT - 16'd1;
`else
  localparam logic [3:0]          DONE_IDX     = 4'(N_STAGES);
`endif

  logic                rst_int;
  logic                lock_meta;
  logic                lock_sync;

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [15:0]         filt_q, filt_d;
  logic [15:0]         dly_q, dly_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic [7:0]          relock_q, relock_d;
  logic [N_STAGES-1:0] cur_mask;
  logic                lock_lost;

`ifdef RST_SEQ_ACK_EN
  logic [15:0]         tmo_q, tmo_d;
  logic                fault_q, fault_d;
  logic                ack_hit;
`else
  logic                unused_cfg;
`endif

  // Internal reset: asserts together with rst_i, so every register below
  // (and therefore stage_rst_o) goes to its reset value without waiting
  // for a clock edge.
  rst_sync u_rst_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .sync_rst (rst_int)
  );

  // Lock crosses in from the PLL domain through two flops.
  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_sync <= lock_meta;
    end
  end

  // One-hot of the stage currently being released; a shift avoids indexing
  // the vectors with an index wider than they need.
  assign cur_mask = ONE_HOT0 << idx_q;

`ifdef RST_SEQ_ACK_EN
  assign ack_hit = |(stage_ack_i & cur_mask);
`else
  assign unused_cfg = ^{stage_ack_i, ACK_TIMEOUT};
`endif

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      filt_q      <= '0;
      dly_q       <= '0;
      stage_rst_q <= '1;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      filt_q      <= filt_d;
      dly_q       <= dly_d;
      stage_rst_q <= stage_rst_d;
      relock_q    <= relock_d;
    end
  end

`ifdef RST_SEQ_ACK_EN
  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end
`endif

  // Next-state logic.  A stage is entered with dly cleared; the stage's
  // reset bit is cleared on the edge that ends its STAGE_DLY-th cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    filt_d      = filt_q;
    dly_d       = dly_q;
    stage_rst_d = stage_rst_q;
    relock_d    = relock_q;
    lock_lost   = 1'b0;
`ifdef RST_SEQ_ACK_EN
    tmo_d       = tmo_q;
    fault_d     = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        stage_rst_d = '1;
        state_d     = ST_WAIT_LOCK;
      end

      ST_WAIT_LOCK: begin
        stage_rst_d = '1;
        if (!lock_sync) begin
          filt_d = '0;
        end else if (filt_q == LOCK_FILT_M1) begin
          filt_d  = '0;
          idx_d   = '0;
          dly_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          filt_d = sat_inc16(filt_q);
        end
      end

      ST_RELEASE: begin
        if (!lock_sync) begin
          lock_lost = 1'b1;
`ifndef RST_SEQ_ACK_EN
        end else if (idx_q == DONE_IDX) begin
          // The last stage released on the previous edge.
          state_d = ST_RUN;
`endif
        end else if (dly_q == STAGE_DLY_M1) begin
          stage_rst_d = stage_rst_q & ~cur_mask;
          dly_d       = '0;
`ifdef RST_SEQ_ACK_EN
          tmo_d       = '0;
          state_d     = ST_WAIT_ACK;
`else
          // The next stage is entered on the same edge this one releases.
          idx_d       = idx_q + 4'd1;
`endif
        end else begin
          dly_d = sat_inc16(dly_q);
        end
      end

`ifdef RST_SEQ_ACK_EN
      ST_WAIT_ACK: begin
        // A timeout beats a simultaneous lock loss; an ack arriving on the
        // last allowed cycle still counts.
        if (!ack_hit && (tmo_q == ACK_TMO_M1)) begin
          stage_rst_d = '1;
          fault_d     = 1'b1;
          state_d     = ST_FAULT;
        end else if (!lock_sync) begin
          lock_lost = 1'b1;
        end else if (ack_hit) begin
          tmo_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
          end else begin
            idx_d   = idx_q + 4'd1;
            dly_d   = '0;
            state_d = ST_RELEASE;
          end
        end else begin
          tmo_d = sat_inc16(tmo_q);
        end
      end

      ST_FAULT: begin
        stage_rst_d = '1;
        fault_d     = 1'b1;
      end
`endif

      ST_RUN: begin
        if (!lock_sync) begin
          lock_lost = 1'b1;
        end
      end

      default: begin
        stage_rst_d = '1;
        state_d     = ST_IDLE;
      end
    endcase

    // Lock loss anywhere in the sequence throws every stage back into reset.
    if (lock_lost) begin
      state_d     = ST_WAIT_LOCK;
      idx_d       = '0;
      filt_d      = '0;
      dly_d       = '0;
      stage_rst_d = '1;
      relock_d    = sat_inc8(relock_q);
`ifdef RST_SEQ_ACK_EN
      tmo_d       = '0;
`endif
    end
  end

  assign stage_rst_o  = stage_rst_q;
  assign all_ready_o  = (state_q == ST_RUN);
  assign relock_cnt_o = relock_q;
  assign state_o      = state_q;
`ifdef RST_SEQ_ACK_EN
  assign fault_o      = fault_q;
`else
  assign fault_o      = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl -- testbench for rst_seq_ctrl with default parameters
// (4 stages, 255-cycle stage delay, 8-cycle lock filter).  Define
// RST_SEQ_ACK_EN to build it against the acknowledge variant, where the
// acknowledge timeout is shortened to 100 cycles.

`timescale 1ns/1ps

module tb_rst_seq_ctrl;

  localparam int DLY       = 255;
  localparam int LOCK_FILT = 8;
`ifdef RST_SEQ_ACK_EN
  localparam int          GAP    = 1;
  localparam logic [15:0] TB_TMO = 16'd100;
`else
  localparam int          GAP    = 0;
  localparam logic [15:0] TB_TMO = 16'hffff;
`endif

  typedef struct {
    int         off;
    logic [3:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic [3:0] stage_ack = 4'hf;
  logic [3:0] stage_rst;
  logic       all_ready;
  logic       fault;
  logic [7:0] relock_cnt;
  logic [2:0] state;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         exp_relock = 0;
  exp_t       sb[$];

  rst_seq_ctrl #(
    .N_STAGES    (4),
    .STAGE_DLY   (16'h00ff),
    .LOCK_FILT   (LOCK_FILT),
    .ACK_TIMEOUT (TB_TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_lock_i   (pll_lock),
    .stage_ack_i  (stage_ack),
    .stage_rst_o  (stage_rst),
    .all_ready_o  (all_ready),
    .fault_o      (fault),
    .relock_cnt_o (relock_cnt),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (stage_rst !== 4'hf) begin tests_failed++; $display("[TB] FAIL reset_stage_rst: got %h, expected f", stage_rst); end
    tests_run++;
    if (all_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_all_ready: got %b, expected 0", all_ready); end
    tests_run++;
    if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault: got %b, expected 0", fault); end
    tests_run++;
    if (relock_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_relock: got %h, expected 00", relock_cnt); end
    tests_run++;
    if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d, expected 0", state); end
    rst = 1'b0;
    exp_relock = 0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (state !== 3'd1) begin tests_failed++; $display("[TB] FAIL idle_to_wait_lock: got %0d, expected 1", state); end
    tests_run++;
    if (stage_rst !== 4'hf) begin tests_failed++; $display("[TB] FAIL wait_lock_stage_rst: got %h, expected f", stage_rst); end
  endtask

  // Lock high for one cycle fewer than the filter needs must not start.
  task automatic test_lock_filter();
    for (int i = 0; i < 25; i++) begin
      pll_lock = (i < LOCK_FILT - 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      tests_run++;
      if (state !== 3'd1 || stage_rst !== 4'hf) begin
        tests_failed++;
        $display("[TB] FAIL lock_filter_short: got state %0d rst %h, expected state 1 rst f", state, stage_rst);
      end
    end
  endtask

  task automatic test_sequence();
    int         off;
    int         last_rel;
    logic [3:0] prev;
    logic [3:0] v;
    exp_t       e;
    pll_lock = 1'b1;
    off = 0;
    while (state !== 3'd2 && off < 40) begin @(negedge clk); off++; end
    tests_run++;
    if (off != LOCK_FILT + 2) begin tests_failed++; $display("[TB] FAIL lock_latency: got %0d, expected %0d", off, LOCK_FILT + 2); end
    v = 4'hf;
    last_rel = 0;
    for (int k = 0; k < 4; k++) begin
      v = v << 1;
      e.off = (k + 1) * DLY + k * GAP;
      e.val = v;
      sb.push_back(e);
      last_rel = e.off;
    end
    off = 0;
    prev = stage_rst;
    while (sb.size() != 0 && off < 1200) begin
      @(negedge clk);
      off++;
      if (stage_rst !== prev) begin
        e = sb.pop_front();
        tests_run++;
        if (stage_rst !== e.val || off != e.off) begin
          tests_failed++;
          $display("[TB] FAIL stage_release: got %b at +%0d, expected %b at +%0d", stage_rst, off, e.val, e.off);
        end
        prev = stage_rst;
      end
    end
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL stage_release_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    while (all_ready !== 1'b1 && off < 1300) begin @(negedge clk); off++; end
    tests_run++;
    if (off != last_rel + 1) begin tests_failed++; $display("[TB] FAIL ready_latency: got +%0d, expected +%0d", off, last_rel + 1); end
    tests_run++;
    if (state !== 3'd4) begin tests_failed++; $display("[TB] FAIL run_state: got %0d, expected 4", state); end
  endtask

  task automatic test_relock();
    int off;
    pll_lock = 1'b0;
    off = 0;
    while (state !== 3'd1 && off < 10) begin @(negedge clk); off++; end
    exp_relock = (exp_relock == 255) ? 255 : exp_relock + 1;
    tests_run++;
    if (off != 3) begin tests_failed++; $display("[TB] FAIL relock_latency: got %0d, expected 3", off); end
    tests_run++;
    if (stage_rst !== 4'hf) begin tests_failed++; $display("[TB] FAIL relock_stage_rst: got %h, expected f", stage_rst); end
    tests_run++;
    if (relock_cnt !== 8'(exp_relock)) begin tests_failed++; $display("[TB] FAIL relock_count: got %0d, expected %0d", relock_cnt, exp_relock); end
    tests_run++;
    if (all_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL relock_ready: got %b, expected 0", all_ready); end
  endtask

  task automatic test_async_reset();
    int off;
    pll_lock = 1'b1;
    off = 0;
    while (stage_rst !== 4'b1100 && off < 800) begin @(negedge clk); off++; end
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (stage_rst !== 4'hf) begin tests_failed++; $display("[TB] FAIL async_reset_stage_rst: got %h, expected f", stage_rst); end
    tests_run++;
    if (state !== 3'd0) begin tests_failed++; $display("[TB] FAIL async_reset_state: got %0d, expected 0", state); end
    tests_run++;
    if (relock_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL async_reset_relock: got %h, expected 00", relock_cnt); end
    exp_relock = 0;
    pll_lock = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (state !== 3'd1) begin tests_failed++; $display("[TB] FAIL restart_state: got %0d, expected 1", state); end
  endtask

`ifdef RST_SEQ_ACK_EN
  task automatic test_ack_timeout();
    int off;
    int wait_ack_at;
    rst = 1'b1;
    pll_lock = 1'b0;
    stage_ack = 4'b1101;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_relock = 0;
    repeat (5) @(negedge clk);
    pll_lock = 1'b1;
    off = 0;
    while (state !== 3'd2 && off < 40) begin @(negedge clk); off++; end
    wait_ack_at = 2 * DLY + 1;
    off = 0;
    while (state !== 3'd5 && off < 900) begin
      @(negedge clk);
      off++;
      // Synchronized lock falls exactly in the last timeout cycle.
      if (off == wait_ack_at + int'(TB_TMO) - 3) pll_lock = 1'b0;
    end
    tests_run++;
    if (off != wait_ack_at + int'(TB_TMO)) begin tests_failed++; $display("[TB] FAIL fault_latency: got +%0d, expected +%0d", off, wait_ack_at + int'(TB_TMO)); end
    tests_run++;
    if (fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL fault_flag: got %b, expected 1", fault); end
    tests_run++;
    if (relock_cnt !== 8'h00) begin tests_failed++; $display("[TB] FAIL fault_beats_relock: got %h, expected 00", relock_cnt); end
    repeat (30) @(negedge clk);
    tests_run++;
    if (state !== 3'd5 || fault !== 1'b1 || stage_rst !== 4'hf) begin
      tests_failed++;
      $display("[TB] FAIL fault_hold: got state %0d fault %b rst %h, expected 5 1 f", state, fault, stage_rst);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (fault !== 1'b0 || state !== 3'd0) begin tests_failed++; $display("[TB] FAIL fault_clear: got fault %b state %0d, expected 0 0", fault, state); end
    stage_ack = 4'hf;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask
`endif

  task automatic test_saturate();
    int  off;
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_relock = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      off = 0;
      while (state !== 3'd2 && off < 40) begin @(negedge clk); off++; end
      pll_lock = 1'b0;
      off = 0;
      while (state !== 3'd1 && off < 10) begin @(negedge clk); off++; end
      exp_relock = (exp_relock == 255) ? 255 : exp_relock + 1;
      tests_run++;
      if (relock_cnt !== 8'(exp_relock)) begin
        tests_failed++;
        $display("[TB] FAIL relock_sat_step: got %0d, expected %0d", relock_cnt, exp_relock);
        break;
      end
    end
    tests_run++;
    if (relock_cnt !== 8'hff) begin tests_failed++; $display("[TB] FAIL relock_saturated: got %h, expected ff", relock_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock_filter();
    test_sequence();
    test_relock();
    test_sequence();
    test_relock();
    test_async_reset();
    test_sequence();
`ifdef RST_SEQ_ACK_EN
    test_ack_timeout();
`endif
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter N_STAGES, default 4: number of sequenced reset outputs, range 1..8.
REQ-002 Parameter STAGE_DLY, default 16'h00ff: cycles from entering a stage to releasing its reset, minimum 1.
REQ-003 Parameter LOCK_FILT, default 8: consecutive cycles pll_lock_i must be high to be accepted, minimum 1.
REQ-004 Parameter ACK_TIMEOUT, default 16'hffff: maximum wait for a stage acknowledge (ACK build only).
REQ-005 Port clk_i, input, 1: single clock for all logic.
REQ-006 Port rst_i, input, 1: reset, asynchronous, active-high; fed by the power-on reset pulse generator's output.
REQ-007 Port pll_lock_i, input, 1: PLL lock, asynchronous to clk_i, double-flopped internally.
REQ-008 Port stage_ack_i, input, N_STAGES: per-stage init-done; used only when RST_SEQ_ACK_EN is defined.
REQ-009 Port stage_rst_o, output, N_STAGES: per-stage reset, active-high, released in ascending index order.
REQ-010 Port all_ready_o, output, 1: high only in state RUN.
REQ-011 Port fault_o, output, 1: sticky acknowledge-timeout flag.
REQ-012 Port relock_cnt_o, output, 8: count of lock losses after first release, saturating at 8'hff.
REQ-013 Port state_o, output, 3: current FSM state encoding for debug.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_LOCK, RELEASE, WAIT_ACK, RUN, FAULT.
REQ-015 IDLE SHALL go to WAIT_LOCK one cycle after the internal synchronized reset deasserts.
REQ-016 WAIT_LOCK: filter counter increments while synchronized lock is high, clears when low; at LOCK_FILT consecutive high cycles go to RELEASE with stage index 0.
REQ-017 RELEASE: stage_rst_o[idx] SHALL deassert exactly STAGE_DLY cycles after entering the stage; higher-index bits stay asserted.
REQ-018 Without ACK, the next stage SHALL start on the cycle stage idx releases; after stage N_STAGES-1 releases, enter RUN next cycle.
REQ-019 With ACK, after release go to WAIT_ACK; stage_ack_i[idx] high advances to the next stage or RUN; ACK_TIMEOUT cycles without ack go to FAULT.
REQ-020 Lock loss (synchronized lock low) in RELEASE, WAIT_ACK or RUN SHALL assert all stage_rst_o next cycle, clear idx and counters, increment relock_cnt_o, return to WAIT_LOCK.
REQ-021 FAULT SHALL hold all stage_rst_o asserted and fault_o high; exit only via rst_i.
REQ-022 Timeout and lock loss in the same cycle: FAULT wins, relock_cnt_o not incremented.
REQ-023 Delay and timeout counters SHALL be 16 bits and never wrap; they clear on every stage entry.

Reset
REQ-024 rst_i SHALL assert all stage_rst_o asynchronously; internal reset deassertion synchronized by a 2-flop stage.
REQ-025 Reset values: stage_rst_o all ones, all_ready_o 0, fault_o 0, relock_cnt_o 0, state_o IDLE.
REQ-026 rst_i asserted mid-sequence SHALL abort immediately and restart from IDLE after release.

Configuration
REQ-027 Macro RST_SEQ_ACK_EN defined: WAIT_ACK state, timeout counter and fault_o active.
REQ-028 Macro undefined: stage_ack_i ignored, WAIT_ACK/FAULT unreachable, fault_o tied 0.

Structure
REQ-029 Package rst_seq_pkg SHALL hold the state encoding and default parameter constants.
REQ-030 Sub-module rst_sync (async-assert, sync-deassert, 2 flops) SHALL generate the internal reset.

Verification
REQ-031 rst_i low, lock high constant, defaults, no ACK -> stage_rst_o[0] drops 255 cycles after RELEASE entry, [3] at 1020, all_ready_o next cycle.
REQ-032 Lock pulses high 7 cycles then low, LOCK_FILT=8 -> stays WAIT_LOCK, stage_rst_o stays 4'hf.
REQ-033 Lock drops in RUN -> stage_rst_o 4'hf next cycle, relock_cnt_o 1, full sequence repeats after lock returns.
REQ-034 ACK build, stage_ack_i[1] never rises, ACK_TIMEOUT=100 -> FAULT after 100 cycles, fault_o 1, holds until rst_i.
REQ-035 rst_i asserted during stage 2 delay -> stage_rst_o 4'hf same cycle asynchronously, state_o IDLE.
REQ-036 relock forced 300 times -> relock_cnt_o saturates at 8'hff.
